wiredpanda_logic_bank: RTL and testbench
========================================

# wiredpanda_logic_bank

Parametrised, clocked successor to the generated push-button/LED gate modules. CHANNELS independent gate channels each take two raw push-button inputs, debounce them, and evaluate a per-channel runtime-selectable gate function (AND/OR/XOR/NOT-A) into a registered LED output. A shared debounced mode button cycles the gate function of the channel addressed by `mode_sel`. The block sits between board push buttons and LEDs in generated FPGA top-levels.

## Interface
- `CHANNELS`, 4: number of gate channels, 1..32.
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples required to accept a new input level, ≥2.
- `SEL_W`, max(1, $clog2(CHANNELS)): derived width of `mode_sel`, not to be overridden.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `input_a`  in  CHANNELS  raw push button A per channel, asynchronous to `clk`.
- `input_b`  in  CHANNELS  raw push button B per channel, asynchronous.
- `input_mode_btn`  in  1  raw mode-cycle push button, asynchronous.
- `mode_sel`  in  SEL_W  channel whose mode a press advances; synchronous to `clk`.
- `output_led`  out  CHANNELS  registered gate result per channel.
- `output_mode`  out  2*CHANNELS  channel i mode at bits [2i+1:2i].
- `output_mode_event`  out  1  one-cycle pulse after any mode update.

## Operation
- Each raw input (2*CHANNELS+1 bits) passes a 2-flop synchroniser, then a debouncer: per-bit `stable` and `count` (width $clog2(DEBOUNCE_CYCLES)).
- Debounce, per edge: if sync==stable, count←0; else if count==DEBOUNCE_CYCLES-1, stable←sync, count←0; else count←count+1. Any glitch back to `stable` restarts the count.
- Mode encoding: AND=0, OR=1, XOR=2, NOT_A=3. Advance: 0→1→2→3→0 (wraps).
- `press`: registered, high exactly one cycle after mode-button `stable` goes 0→1. Releasing the button produces no event; a held button advances once.
- On `press`: if mode_sel < CHANNELS, mode[mode_sel] advances and `output_mode_event` is high the following cycle; if mode_sel ≥ CHANNELS, ignored, no event.
- `output_led[i]` ← f(mode[i], a_stable[i], b_stable[i]) every cycle; NOT_A ignores B.
- Reset values: sync flops, stable, count, press 0; all modes AND; `output_led` 0; `output_mode` 0; `output_mode_event` 0.

## Timing
- Raw input changes and is held; edge 0 is the first sampling edge. `stable` updates at edge DEBOUNCE_CYCLES+1; `output_led` reflects it at edge DEBOUNCE_CYCLES+2.
- Mode button: `press` high after edge D+2 (D=DEBOUNCE_CYCLES); mode register updates at edge D+3; `output_led` uses the new mode at edge D+4; `output_mode_event` high between edges D+3 and D+4.
- Mode change and input change in the same cycle: the LED register samples the current mode and current stable values; no priority conflict.
- Reset mid-debounce: partial count discarded. A button held through reset is seen as a fresh 0→1 afterwards and produces one press, D+3 edges after the first post-reset edge.
- `rst` has priority over all updates in the same edge.

## Structure
- Package `wiredpanda_logic_pkg` holds the mode enum (2-bit), the `next_mode` function and the `gate_eval(mode,a,b)` function.
- Sub-module `wiredpanda_debounce` is parameterised by WIDTH and DEBOUNCE_CYCLES and contains the synchroniser and debouncer, with outputs `stable[WIDTH]` and registered `rise[WIDTH]`. It is instantiated once with WIDTH = 2*CHANNELS+1.
- The top level holds the mode registers, the LED registers and the event flop.

## Test plan
- Reset: with CHANNELS=4, D=4, all inputs 1 during `rst` → `output_led`=0, `output_mode`=0x00, event=0. Afterwards the button held through reset yields one press, so mode[mode_sel] becomes 1.
- AND path: a[0]=b[0]=1 held from edge 0 → led[0]=0 through edge 5, and led[0]=1 at edge 6.
- Bounce: a[1] high 3 cycles, low 1, then high held, with b[1]=1 → led[1] rises 6 edges after the final rising transition, not earlier.
- Mode cycling: mode_sel=2, four separate presses → mode[2] steps 1, 2, 3, 0. There is one event pulse per press, and a held button gives no repeats. In NOT_A, a[2]=0 → led[2]=1.
- Out-of-range select: instance with CHANNELS=3, mode_sel=3, press → `output_mode` unchanged, no event.
- Reset mid-debounce: a[3]=1 (b[3]=1) and `rst` pulsed at count=2 → led[3] stays 0, then rises D+2 edges after the first post-reset edge.

Source files
------------

// File: rtl/wiredpanda_logic_pkg.sv
// Shared types and helpers for the push-button gate bank: mode encoding,
// mode advance and the per-channel gate function.
package wiredpanda_logic_pkg;

    typedef enum logic [1:0] {
        MODE_AND   = 2'd0,
        MODE_OR    = 2'd1,
        MODE_XOR   = 2'd2,
        MODE_NOT_A = 2'd3
    } mode_e;

    // Wraps NOT_A back to AND through the natural 2-bit overflow.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

    function automatic logic gate_eval(input mode_e m, input logic a, input logic b);
        case (m)
            MODE_AND:   gate_eval = a & b;
            MODE_OR:    gate_eval = a | b;
            MODE_XOR:   gate_eval = a ^ b;
            MODE_NOT_A: gate_eval = ~a;
            default:    gate_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wiredpanda_debounce.sv
// Two-flop synchroniser plus counting debouncer for WIDTH raw buttons.
// o_rise is a registered one-cycle pulse following each 0->1 of o_stable.
module wiredpanda_debounce #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] r_sync1, r_sync2, r_stable, r_stable_d, r_rise;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            r_rise     <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1    <= i_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_rise     <= r_stable & ~r_stable_d;
            // Any sample matching the accepted level restarts the run.
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;

endmodule

// File: rtl/wiredpanda_logic_bank.sv
// Bank of debounced two-input gate channels with a shared mode button that
// advances the gate function of the channel picked by mode_sel.
module wiredpanda_logic_bank
    import wiredpanda_logic_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SEL_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   input_a,
    input  logic [CHANNELS-1:0]   input_b,
    input  logic                  input_mode_btn,
    input  logic [SEL_W-1:0]      mode_sel,
    output logic [CHANNELS-1:0]   output_led,
    output logic [2*CHANNELS-1:0] output_mode,
    output logic                  output_mode_event
);
    localparam int NB = 2*CHANNELS + 1;

    logic [NB-1:0]       w_raw, w_stable, w_rise;
    logic [CHANNELS-1:0] w_a, w_b;
    logic                w_press, w_sel_ok, w_unused_rise;

    // Bit layout: A lanes low, B lanes next, mode button on top.
    assign w_raw = {input_mode_btn, input_b, input_a};

    wiredpanda_debounce #(
        .WIDTH          (NB),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (w_raw),
        .o_stable(w_stable),
        .o_rise  (w_rise)
    );

    assign w_a           = w_stable[CHANNELS-1:0];
    assign w_b           = w_stable[2*CHANNELS-1:CHANNELS];
    assign w_press       = w_rise[NB-1];
    assign w_unused_rise = ^w_rise[NB-2:0];
    assign w_sel_ok      = 32'(mode_sel) < CHANNELS;

    mode_e                r_mode [CHANNELS];
    logic [CHANNELS-1:0]  r_led;
    logic                 r_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led   <= '0;
            r_event <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) r_mode[i] <= MODE_AND;
        end else begin
            r_event <= w_press && w_sel_ok;
            // LED samples the pre-update mode, so a same-cycle press lands one edge later.
            for (int i = 0; i < CHANNELS; i++) begin
                r_led[i] <= gate_eval(r_mode[i], w_a[i], w_b[i]);
                if (w_press && w_sel_ok && (mode_sel == SEL_W'(i)))
                    r_mode[i] <= next_mode(r_mode[i]);
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_mode_out
        assign output_mode[2*g +: 2] = r_mode[g];
    end

    assign output_led        = r_led;
    assign output_mode_event = r_event;

endmodule

// File: tb/tb_wiredpanda_logic_bank.sv
// Randomised bench for the gate bank: a 4-channel and a 3-channel instance
// checked every cycle against a window-based reference model.
module tb_wiredpanda_logic_bank;
    localparam int D    = 4;
    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       btn;
    logic [1:0] sel;
    logic [3:0] led;
    logic [7:0] mode;
    logic       ev;
    logic [2:0] as3, bs3;
    logic       btn3;
    logic [1:0] sel3;
    logic [2:0] led3;
    logic [5:0] mode3;
    logic       ev3;

    always #5 clk = ~clk;

    wiredpanda_logic_bank #(.CHANNELS(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .input_a(a), .input_b(b), .input_mode_btn(btn),
        .mode_sel(sel), .output_led(led), .output_mode(mode), .output_mode_event(ev)
    );

    wiredpanda_logic_bank #(.CHANNELS(3), .DEBOUNCE_CYCLES(D)) dut3 (
        .clk(clk), .rst(rst), .input_a(as3), .input_b(bs3), .input_mode_btn(btn3),
        .mode_sel(sel3), .output_led(led3), .output_mode(mode3), .output_mode_event(ev3)
    );

    int n_vec = 0;
    int n_err = 0;
    int n     = 0;

    // Reference state per instance: raw sample history, accepted level,
    // edge of last accepted change (or reset), edge of last button rise.
    bit hist   [2][9][MAXE];
    bit ms     [2][9];
    int mflip  [2][9];
    int mrose  [2];
    int mmode  [2][4];
    bit mled   [2][4];
    bit mev    [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic bit gate_ref(input int m, input bit x, input bit y);
        case (m)
            0: return bit'((x + y) == 2);
            1: return bit'((x + y) >= 1);
            2: return bit'((x + y) == 1);
            default: return bit'(1 - x);
        endcase
    endfunction

    task automatic model_inst(input int k, input bit r, input bit [8:0] v, input int s);
        int c  = (k == 0) ? 4 : 3;
        int nb = 2*c + 1;
        bit os [9];
        for (int i = 0; i < nb; i++) os[i] = ms[k][i];
        if (r) begin
            for (int i = 0; i < nb; i++) begin
                hist[k][i][n] = 1'b0;
                if (n > 0) hist[k][i][n-1] = 1'b0;
                ms[k][i]    = 1'b0;
                mflip[k][i] = n;
            end
            for (int i = 0; i < 4; i++) begin mmode[k][i] = 0; mled[k][i] = 1'b0; end
            mev[k]   = 1'b0;
            mrose[k] = -100;
            return;
        end
        for (int i = 0; i < c; i++) mled[k][i] = gate_ref(mmode[k][i], os[i], os[c+i]);
        mev[k] = 1'b0;
        if (mrose[k] == n - 2 && s < c) begin
            mmode[k][s] = (mmode[k][s] + 1) % 4;
            mev[k] = 1'b1;
        end
        // A new level is accepted once the last D synchronised samples (raw
        // delayed two edges) all differ from it, counted since the last change.
        for (int i = 0; i < nb; i++) begin
            bit all_diff;
            hist[k][i][n] = v[i];
            if (n - D + 1 > mflip[k][i]) begin
                all_diff = 1'b1;
                for (int j = n - D + 1; j <= n; j++) begin
                    bit smp = (j - 2 >= 0) ? hist[k][i][j-2] : 1'b0;
                    if (smp == os[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    ms[k][i]    = ~os[i];
                    mflip[k][i] = n;
                    if (i == nb - 1 && ms[k][i]) mrose[k] = n;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] el;  logic [7:0] em;
        logic [2:0] el3; logic [5:0] em3;
        for (int i = 0; i < 4; i++) begin el[i] = mled[0][i]; em[2*i +: 2] = 2'(mmode[0][i]); end
        for (int i = 0; i < 3; i++) begin el3[i] = mled[1][i]; em3[2*i +: 2] = 2'(mmode[1][i]); end
        chk("led4",  32'(led),  32'(el));
        chk("mode4", 32'(mode), 32'(em));
        chk("evt4",  32'(ev),   32'(mev[0]));
        chk("led3",  32'(led3), 32'(el3));
        chk("mode3", 32'(mode3), 32'(em3));
        chk("evt3",  32'(ev3),  32'(mev[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_inst(0, rst, {4'b0, btn, b, a}, int'(sel));
        model_inst(1, rst, {2'b0, btn3, bs3, as3}, int'(sel3));
        n++;
        @(negedge clk);
        check_all();
    endtask

    task automatic set_all(input logic v);
        a = {4{v}}; b = {4{v}}; btn = v; as3 = {3{v}}; bs3 = {3{v}}; btn3 = v;
    endtask

    initial begin
        rst = 1'b1; set_all(1'b0); sel = 2'd0; sel3 = 2'd3;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (10) cyc();

        // AND path latency: both inputs rise before edge 0.
        a[0] = 1'b1; b[0] = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            cyc();
            chk("and_lat", 32'(led[0]), 32'(k >= 6));
        end

        // Everything held high through reset; button seen as one fresh press.
        rst = 1'b1; set_all(1'b1); sel = 2'd2;
        repeat (3) cyc();
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_mode", 32'(mode), 32'h0);
        rst = 1'b0;
        repeat (8) cyc();
        chk("rst_press", 32'(mode), 32'h10);
        chk("rst_press3", 32'(mode3), 32'h0);
        set_all(1'b0);
        repeat (12) cyc();

        // Slow random toggling so levels get through the debouncer, with bounce.
        for (int t = 0; t < 2600; t++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) a[i] = ~a[i];
                if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
            end
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) as3[i] = ~as3[i];
                if ($urandom_range(0, 5) == 0) bs3[i] = ~bs3[i];
            end
            if ($urandom_range(0, 6) == 0) btn  = ~btn;
            if ($urandom_range(0, 6) == 0) btn3 = ~btn3;
            if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
            sel3 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
            rst  = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
